seq_detector_prog: RTL
======================

Name: seq_detector_prog

Overview:
- Runtime-programmable serial bit-pattern detector; successor to the fixed-pattern Moore detector.
- Pattern length (1..MAX_LEN), pattern value and overlap mode are loadable at run time.
- Input is valid-qualified; outputs are a registered match pulse and a saturating match counter.
- Sits on serial control/protocol streams wherever framing or marker detection is needed.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (≥1).
- LEN_W, 4, width of cfg_len; must satisfy MAX_LEN ≤ 2^LEN_W−1.
- CNT_W, 16, match counter width.
- DEFAULT_PATTERN, 8'b0000_1011, pattern loaded at reset (MAX_LEN bits).
- DEFAULT_LEN, 4, pattern length loaded at reset (1..MAX_LEN).

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-high.
- cfg_load, input, 1, load cfg_pattern/cfg_len/cfg_overlap this cycle.
- cfg_pattern, input, MAX_LEN, pattern; bit [len−1] is the first-received bit, bit [0] the last.
- cfg_len, input, LEN_W, pattern length.
- cfg_overlap, input, 1, 1 = overlapping matches allowed, 0 = non-overlapping.
- cfg_err, output, 1, one-cycle pulse: rejected load.
- in_valid, input, 1, in_bit is sampled when high.
- in_bit, input, 1, serial data bit.
- clr_count, input, 1, synchronous clear of match_count.
- match, output, 1, one-cycle pulse per detected pattern.
- match_count, output, CNT_W, saturating count of matches.
- armed, output, 1, high when history holds at least len valid bits.

Behaviour:
- Decided: reset reset, asynchronous, active-high; clock clock.
- Reset state: pattern=DEFAULT_PATTERN, len=DEFAULT_LEN, overlap=1, history=0, fill=0, FSM=FILL. Outputs: match=0, match_count=0, cfg_err=0, armed=0.
- History: MAX_LEN-bit shift register. On an accepted bit, hist <= {hist[MAX_LEN−2:0], in_bit}.
- Fill counter: increments on each accepted bit and saturates at len.
- FSM states:
  - FILL: fill < len.
  - ARMED: fill == len; armed=1 exactly in this state.
  - Transitions: FILL→ARMED when an accepted bit makes fill reach len. ARMED→FILL on a non-overlap match or a config load. ARMED self-loops otherwise.
- Match condition (evaluated on the next history/fill values): in_valid=1 AND next_fill ≥ len AND next_hist[len−1:0] == pattern[len−1:0]. Upper bits are ignored.
- Latency: match is registered and asserts the cycle after the clock edge that sampled the completing bit. It is low in all other cycles.
- Overlap=1: history and fill are untouched on a match, so suffix reuse is allowed.
- Overlap=0: on a match, fill clears to 0 and the FSM returns to FILL; the next match needs len fresh bits.
- in_valid=0: history, fill and FSM hold; match=0 in the following cycle.
- cfg_load with 1 ≤ cfg_len ≤ MAX_LEN:
  - Latch pattern, len and overlap; clear history and fill; FSM→FILL.
  - Any in_valid bit in the same cycle is discarded.
  - No match is generated from that cycle.
  - match_count is not affected.
- cfg_load with cfg_len=0 or cfg_len>MAX_LEN:
  - Configuration, history and fill are unchanged; the in_valid bit in that cycle is processed normally.
  - cfg_err pulses high for one cycle (registered, next cycle).
- match_count: increments by 1 on each match (same edge that sets match) and saturates at 2^CNT_W−1.
- clr_count:
  - Alone: count → 0.
  - With a simultaneous match: count → 1 (the match is never lost).
- Reset mid-stream: partial history is discarded and configuration reverts to defaults.

Test Plan:
- Defaults (1011, overlap), in_valid=1, stream 1,0,1,1,0,1,1 -> match pulses one cycle after bits 4 and 7; match_count=2; armed rises after bit 4.
- Load pattern 1011, len 4, overlap=0, same stream -> single match after bit 4; match_count=1; armed=0 after the match.
- Defaults, stream 1,0,1,1 with in_valid=0 for two cycles between bits 2 and 3 (in_bit toggling while invalid) -> exactly one match after bit 4.
- cfg_load with cfg_len=9 (MAX_LEN=8) -> cfg_err pulses 1 cycle; stream 1011 still matches at default. cfg_load with cfg_len=0 -> same result.
- CNT_W=2, pattern len 1 value 1, overlap=1, six 1-bits -> match_count goes 1,2,3,3,3,3. clr_count together with a match -> match_count=1.
- Stream 1,0,1, assert reset for 1 cycle, then 1 -> no match; then 0,1,1 -> match after the last bit.

Source files
------------

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector: loadable pattern/length/overlap,
// valid-qualified input, registered match pulse and saturating match counter.
module seq_detector_prog #(
  parameter int                 MAX_LEN         = 8,
  parameter int                 LEN_W           = 4,
  parameter int                 CNT_W           = 16,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(8'b0000_1011),
  parameter int                 DEFAULT_LEN     = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               clr_count,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed
);

  typedef enum logic [0:0] {ST_FILL = 1'b0, ST_ARMED = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               cfg_err_q, cfg_err_d;
  logic               armed_q, armed_d;

  logic               cfg_ok_s;
  logic [MAX_LEN:0]   hist_ext_s;
  logic [MAX_LEN-1:0] mask_s;
  logic [LEN_W-1:0]   fill_next_s;

  // Next-state computation for configuration, history, FSM and counter
  always_comb begin
    pattern_d   = pattern_q;
    len_d       = len_q;
    overlap_d   = overlap_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    state_d     = state_q;
    match_d     = 1'b0;
    count_d     = count_q;
    cfg_ok_s    = cfg_load && (cfg_len != {LEN_W{1'b0}}) && (cfg_len <= LEN_W'(MAX_LEN));
    cfg_err_d   = cfg_load && !cfg_ok_s;
    hist_ext_s  = {hist_q, in_bit};
    fill_next_s = (fill_q < len_q) ? (fill_q + LEN_W'(1)) : fill_q;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask_s[i] = (LEN_W'(i) < len_q);
    end

    if (cfg_ok_s) begin
      // A good load restarts detection; the same-cycle input bit is dropped.
      pattern_d = cfg_pattern;
      len_d     = cfg_len;
      overlap_d = cfg_overlap;
      hist_d    = {MAX_LEN{1'b0}};
      fill_d    = {LEN_W{1'b0}};
      state_d   = ST_FILL;
    end else if (in_valid) begin
      hist_d  = hist_ext_s[MAX_LEN-1:0];
      fill_d  = fill_next_s;
      match_d = (fill_next_s >= len_q) && (((hist_d ^ pattern_q) & mask_s) == {MAX_LEN{1'b0}});
      if (match_d && !overlap_q) begin
        fill_d  = {LEN_W{1'b0}};
        state_d = ST_FILL;
      end else begin
        state_d = (fill_next_s == len_q) ? ST_ARMED : ST_FILL;
      end
    end else begin
      state_d = state_q;
    end

    if (clr_count) begin
      count_d = match_d ? CNT_W'(1) : {CNT_W{1'b0}};
    end else if (match_d && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end

    armed_d = (state_d == ST_ARMED);
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FILL;
      pattern_q <= DEFAULT_PATTERN;
      len_q     <= LEN_W'(DEFAULT_LEN);
      overlap_q <= 1'b1;
      hist_q    <= {MAX_LEN{1'b0}};
      fill_q    <= {LEN_W{1'b0}};
      match_q   <= 1'b0;
      count_q   <= {CNT_W{1'b0}};
      cfg_err_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      count_q   <= count_d;
      cfg_err_q <= cfg_err_d;
      armed_q   <= armed_d;
    end
  end

  assign match       = match_q;
  assign match_count = count_q;
  assign cfg_err     = cfg_err_q;
  assign armed       = armed_q;

endmodule
